// File: rtl/systolic_seq_if.sv
// systolic_seq_if: bundle of the sequencer's host-side and array-side signals.
//   Command:    i_cmd_vld / o_cmd_rdy / i_cmd_load / i_cmd_len
//   Weights:    i_wgt_vld / o_wgt_rdy / i_wgt_data
//   Activation: i_act_vld / o_act_rdy / i_act_data (row r at bits [r*W +: W])
//   Array side: o_load_vld / o_load_id / o_load_data, o_pop_vld, o_left_data
//   Status:     o_done; o_busy_cyc / o_stall_cyc when SYSTOLIC_SEQ_PERF_EN is defined
// slave is the sequencer's view, master is the host/bench view.
interface systolic_seq_if #(
   parameter int ROWS          = 4,
   parameter int ID_WIDTH      = 6,
   parameter int IN_DATA_WIDTH = 8,
   parameter int LEN_WIDTH     = 16
);
   logic                          i_cmd_vld;
   logic                          o_cmd_rdy;
   logic                          i_cmd_load;
   logic [LEN_WIDTH-1:0]          i_cmd_len;
   logic                          i_wgt_vld;
   logic                          o_wgt_rdy;
   logic [IN_DATA_WIDTH-1:0]      i_wgt_data;
   logic                          i_act_vld;
   logic                          o_act_rdy;
   logic [ROWS*IN_DATA_WIDTH-1:0] i_act_data;
   logic                          o_load_vld;
   logic [ID_WIDTH-1:0]           o_load_id;
   logic [IN_DATA_WIDTH-1:0]      o_load_data;
   logic                          o_pop_vld;
   logic [ROWS*IN_DATA_WIDTH-1:0] o_left_data;
   logic                          o_done;
`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [31:0]                   o_busy_cyc;
   logic [31:0]                   o_stall_cyc;
`endif

   modport slave (
      input  i_cmd_vld, i_cmd_load, i_cmd_len, i_wgt_vld, i_wgt_data, i_act_vld, i_act_data,
      output o_cmd_rdy, o_wgt_rdy, o_act_rdy, o_load_vld, o_load_id, o_load_data,
             o_pop_vld, o_left_data, o_done
`ifdef SYSTOLIC_SEQ_PERF_EN
      , output o_busy_cyc, o_stall_cyc
`endif
   );

   modport master (
      output i_cmd_vld, i_cmd_load, i_cmd_len, i_wgt_vld, i_wgt_data, i_act_vld, i_act_data,
      input  o_cmd_rdy, o_wgt_rdy, o_act_rdy, o_load_vld, o_load_id, o_load_data,
             o_pop_vld, o_left_data, o_done
`ifdef SYSTOLIC_SEQ_PERF_EN
      , input o_busy_cyc, o_stall_cyc
`endif
   );
endinterface

// File: rtl/systolic_seq.sv
// systolic_seq: command sequencer for the weight-stationary PE array.
// One command at a time: optionally streams ROWS*COLS weights into the
// ID-addressed load chain, launches len row-skewed activation vectors on the
// left edge, drains for DRAIN_CYCLES cycles, pulses pop on the last drain
// cycle, then pulses done.
// Ports: clk, rst (synchronous, active-high), bus (systolic_seq_if.slave).
// Optional: define SYSTOLIC_SEQ_PERF_EN for the o_busy_cyc / o_stall_cyc
// saturating performance counters.

// One activation lane of the skew stage: DEPTH registers, cleared by rst,
// shifting every cycle.
module systolic_seq_skew_lane #(
   parameter int DEPTH = 1,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   logic [DEPTH-1:0][W-1:0] pipe;

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= din;
         for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
      end
   end

   assign dout = pipe[DEPTH-1];
endmodule

module systolic_seq #(
   parameter int ROWS          = 4,
   parameter int COLS          = 4,
   parameter int ID_WIDTH      = 6,
   parameter int IN_DATA_WIDTH = 8,
   parameter int LEN_WIDTH     = 16,
   parameter int DRAIN_CYCLES  = 24
) (
   input logic          clk,
   input logic          rst,
   systolic_seq_if.slave bus
);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [ID_WIDTH-1:0] LAST_ID    = ID_WIDTH'(ROWS*COLS-1);
   localparam logic [DW-1:0]       LAST_DRAIN = DW'(DRAIN_CYCLES-1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      COMPUTE = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [ID_WIDTH-1:0]      cnt;
   logic [LEN_WIDTH-1:0]     len_cnt;
   logic [DW-1:0]            drain_cnt;
   logic                     cmd_rdy, wgt_rdy, act_rdy, pop_vld, done;
   logic                     cmd_hs, wgt_hs, act_hs;
   logic                     load_vld;
   logic [ID_WIDTH-1:0]      load_id;
   logic [IN_DATA_WIDTH-1:0] load_data;
   logic [ROWS*IN_DATA_WIDTH-1:0]     inj;
   logic [ROWS-1:0][IN_DATA_WIDTH-1:0] left;

   assign cmd_hs = cmd_rdy & bus.i_cmd_vld;
   assign wgt_hs = wgt_rdy & bus.i_wgt_vld;
   assign act_hs = act_rdy & bus.i_act_vld;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (cmd_hs) begin
            if (bus.i_cmd_load)          state_nxt = LOAD;
            else if (bus.i_cmd_len != '0) state_nxt = COMPUTE;
            else                          state_nxt = DONE;
         end
         LOAD: if (wgt_hs && cnt == LAST_ID)
            state_nxt = (len_cnt != '0) ? COMPUTE : DONE;
         COMPUTE: if (act_hs && len_cnt == LEN_WIDTH'(1)) state_nxt = DRAIN;
         DRAIN: if (drain_cnt == LAST_DRAIN) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs. Gated by rst so nothing handshakes or pulses while reset
   // is applied, even though the state register only clears at the edge.
   always_comb begin
      cmd_rdy = 1'b0;
      wgt_rdy = 1'b0;
      act_rdy = 1'b0;
      pop_vld = 1'b0;
      done    = 1'b0;
      if (!rst) begin
         case (state)
            IDLE:    cmd_rdy = 1'b1;
            LOAD:    wgt_rdy = 1'b1;
            COMPUTE: act_rdy = 1'b1;
            DRAIN:   pop_vld = (drain_cnt == LAST_DRAIN);
            DONE:    done    = 1'b1;
            default: ;
         endcase
      end
   end

   // Counters and the registered load-chain port. cnt stops at LAST_ID
   // (LOAD exits on that handshake) and is rearmed by the next command.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         len_cnt   <= '0;
         drain_cnt <= '0;
         load_vld  <= 1'b0;
         load_id   <= '0;
         load_data <= '0;
      end else begin
         load_vld <= wgt_hs;
         if (wgt_hs) begin
            load_id   <= cnt;
            load_data <= bus.i_wgt_data;
            if (cnt != LAST_ID) cnt <= cnt + 1'b1;
         end
         if (cmd_hs) begin
            cnt       <= '0;
            len_cnt   <= bus.i_cmd_len;
            drain_cnt <= '0;
         end
         if (act_hs) len_cnt <= len_cnt - 1'b1;
         if (state == DRAIN)
            drain_cnt <= (drain_cnt == LAST_DRAIN) ? '0 : drain_cnt + 1'b1;
      end
   end

   // Skew stage: zeros are injected on every cycle without an activation
   // handshake, so the array sees clean bubbles during load/drain/idle.
   assign inj = act_hs ? bus.i_act_data : '0;

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      systolic_seq_skew_lane #(.DEPTH(r+1), .W(IN_DATA_WIDTH)) u_lane (
         .clk  (clk),
         .rst  (rst),
         .din  (inj[r*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
         .dout (left[r])
      );
   end

   assign bus.o_cmd_rdy   = cmd_rdy;
   assign bus.o_wgt_rdy   = wgt_rdy;
   assign bus.o_act_rdy   = act_rdy;
   assign bus.o_pop_vld   = pop_vld;
   assign bus.o_done      = done;
   assign bus.o_load_vld  = load_vld;
   assign bus.o_load_id   = load_id;
   assign bus.o_load_data = load_data;
   assign bus.o_left_data = left;

`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [31:0] busy_cyc, stall_cyc;
   logic        stall;

   assign stall = (state == LOAD && !bus.i_wgt_vld) || (state == COMPUTE && !bus.i_act_vld);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_cyc  <= '0;
         stall_cyc <= '0;
      end else begin
         if (state != IDLE && busy_cyc != '1) busy_cyc  <= busy_cyc + 1'b1;
         if (stall && stall_cyc != '1)        stall_cyc <= stall_cyc + 1'b1;
      end
   end

   assign bus.o_busy_cyc  = busy_cyc;
   assign bus.o_stall_cyc = stall_cyc;
`endif
endmodule
